// File: rtl/func_seq_pkg.sv
// Shared definitions for the Functional-unit sequencer: FSM codes, op layout and op unpacking.
package func_seq_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_FETCH = 2'd1;
    localparam logic [1:0] ST_EXEC  = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    localparam int unsigned OP_I_HI   = 7;
    localparam int unsigned OP_I_LO   = 6;
    localparam int unsigned OP_DST_HI = 5;
    localparam int unsigned OP_DST_LO = 4;
    localparam int unsigned OP_SA_HI  = 3;
    localparam int unsigned OP_SA_LO  = 2;
    localparam int unsigned OP_SB_HI  = 1;
    localparam int unsigned OP_SB_LO  = 0;

    localparam int unsigned NREG = 4;
    localparam int unsigned RW   = 2;
    localparam int unsigned OPW  = 8;

    typedef struct packed {
        logic [1:0] i;
        logic [1:0] dst;
        logic [1:0] sa;
        logic [1:0] sb;
    } op_t;

    function automatic op_t to_op(input logic [OPW-1:0] w);
        op_t op;
        op.i   = w[OP_I_HI:OP_I_LO];
        op.dst = w[OP_DST_HI:OP_DST_LO];
        op.sa  = w[OP_SA_HI:OP_SA_LO];
        op.sb  = w[OP_SB_HI:OP_SB_LO];
        return op;
    endfunction

endpackage

// File: rtl/func_seq_regfile.sv
// 4 x 2-bit register file: one write port, operand read ports A/B and a debug read port.
module func_seq_regfile
    import func_seq_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    input  logic          we,
    input  logic [1:0]    waddr,
    input  logic [RW-1:0] wdata,
    input  logic [1:0]    ra_addr,
    output logic [RW-1:0] ra_data,
    input  logic [1:0]    rb_addr,
    output logic [RW-1:0] rb_data,
    input  logic [1:0]    rd_addr,
    output logic [RW-1:0] rd_data
);

    logic [RW-1:0] regs [NREG];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(NREG); i++) regs[i] <= '0;
        end else if (we) begin
            regs[waddr] <= wdata;
        end
    end

    assign ra_data = regs[ra_addr];
    assign rb_data = regs[rb_addr];
    assign rd_data = regs[rd_addr];

endmodule

// File: rtl/func_seq_ctrl.sv
// Sequencer: stores a small op program and issues each op to the Functional unit,
// writing its F result back into the register file.
module func_seq_ctrl
    import func_seq_pkg::*;
#(
    parameter int unsigned DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   op_push,
    input  logic [7:0]             op_word,
    input  logic                   prog_clear,
    input  logic                   reg_we,
    input  logic [1:0]             reg_waddr,
    input  logic [1:0]             reg_wdata,
    input  logic [1:0]             rd_addr,
    output logic [1:0]             rd_data,
    input  logic                   start,
    output logic                   busy,
    output logic                   done,
    output logic [$clog2(DEPTH):0] prog_count,
    output logic                   prog_full,
    output logic [1:0]             fu_a,
    output logic [1:0]             fu_b,
    output logic [1:0]             fu_i,
    input  logic [1:0]             fu_f
);

    localparam int unsigned PW = $clog2(DEPTH);

    logic [1:0]     state, state_d;
    logic [PW-1:0]  ptr, ptr_d;
    logic [PW:0]    count, count_d;
    logic           push_en, fetch_en, wb_en;
    logic [OPW-1:0] prog [DEPTH];
    op_t            cur_op;
    logic [RW-1:0]  ra_data, rb_data;
    logic           rf_we;
    logic [1:0]     rf_waddr;
    logic [RW-1:0]  rf_wdata;

    assign cur_op = to_op(prog[ptr]);

    // Next-state and per-cycle strobes.
    always_comb begin
        state_d  = state;
        ptr_d    = ptr;
        count_d  = count;
        push_en  = 1'b0;
        fetch_en = 1'b0;
        wb_en    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (prog_clear) begin
                    count_d = '0;
                end else if (start) begin
                    ptr_d   = '0;
                    state_d = (count != '0) ? ST_FETCH : ST_DONE;
                end else if (op_push && (count != (PW+1)'(DEPTH))) begin
                    push_en = 1'b1;
                    count_d = count + (PW+1)'(1);
                end
            end
            ST_FETCH: begin
                fetch_en = 1'b1;
                state_d  = ST_EXEC;
            end
            ST_EXEC: begin
                wb_en = 1'b1;
                if ({1'b0, ptr} == count - (PW+1)'(1)) begin
                    state_d = ST_DONE;
                end else begin
                    ptr_d   = ptr + PW'(1);
                    state_d = ST_FETCH;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            ptr       <= '0;
            count     <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            prog_full <= 1'b0;
            fu_a      <= '0;
            fu_b      <= '0;
            fu_i      <= '0;
        end else begin
            state     <= state_d;
            ptr       <= ptr_d;
            count     <= count_d;
            busy      <= (state_d != ST_IDLE);
            done      <= (state_d == ST_DONE);
            prog_full <= (count_d == (PW+1)'(DEPTH));
            if (fetch_en) begin
                fu_i <= cur_op.i;
                fu_a <= ra_data;
                fu_b <= rb_data;
            end
        end
    end

    // Program storage carries no reset; prog_count alone defines validity.
    always_ff @(posedge clk) begin
        if (push_en) prog[count[PW-1:0]] <= op_word;
    end

    // Preload and write-back never overlap: preload is IDLE-only, write-back EXEC-only.
    assign rf_we    = wb_en | ((state == ST_IDLE) & reg_we);
    assign rf_waddr = wb_en ? cur_op.dst : reg_waddr;
    assign rf_wdata = wb_en ? fu_f : reg_wdata;

    func_seq_regfile u_regfile (
        .clk     (clk),
        .rst_n   (rst_n),
        .we      (rf_we),
        .waddr   (rf_waddr),
        .wdata   (rf_wdata),
        .ra_addr (cur_op.sa),
        .ra_data (ra_data),
        .rb_addr (cur_op.sb),
        .rb_data (rb_data),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

    assign prog_count = count;

endmodule
